// File: rtl/mtrap_pkg.sv
// rtl/mtrap_pkg.sv - shared trap sequencer state, PC source and cause encodings
//
// Purpose: the constants the trap sequencer and the mtval/mcause CSR logic agree on.
// Contents: mtrap_state_t (OPERATING, TRAP_TAKEN, TRAP_RETURN, WAIT_IRQ),
//           PC_SRC_* select codes and CAUSE_* mcause[3:0] codes.
package mtrap_pkg;

    typedef enum logic [1:0] {
        OPERATING   = 2'b00,
        TRAP_TAKEN  = 2'b01,
        TRAP_RETURN = 2'b10,
        WAIT_IRQ    = 2'b11
    } mtrap_state_t;

    localparam logic [1:0] PC_SRC_SEQ      = 2'b00;
    localparam logic [1:0] PC_SRC_MTVEC    = 2'b01;
    localparam logic [1:0] PC_SRC_MEPC     = 2'b10;
    localparam logic [1:0] PC_SRC_RESERVED = 2'b11;

    // Exception causes (mcause[31] = 0)
    localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;

    // Interrupt causes (mcause[31] = 1)
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

endpackage

// File: rtl/mtrap_prio_enc.sv
// rtl/mtrap_prio_enc.sv - combinational trap priority encoder
//
// Purpose: picks the single highest-priority trap from the fault and
//          interrupt vectors.
// Ports:
//   instr_misaligned, illegal_instr, ebreak, ecall,
//   load_misaligned, store_misaligned   exception sources
//   mie                                 global interrupt enable
//   meie/mtie/msie, meip/mtip/msip      per-source enable and pending bits
//   take       a trap must be taken
//   is_irq     selected trap is an interrupt
//   cause      mcause[3:0] of the selected trap
//   misaligned selected trap reports a faulting address in mtval
module mtrap_prio_enc
    import mtrap_pkg::*;
(
    input  logic       instr_misaligned,
    input  logic       illegal_instr,
    input  logic       ebreak,
    input  logic       ecall,
    input  logic       load_misaligned,
    input  logic       store_misaligned,
    input  logic       mie,
    input  logic       meie,
    input  logic       mtie,
    input  logic       msie,
    input  logic       meip,
    input  logic       mtip,
    input  logic       msip,
    output logic       take,
    output logic       is_irq,
    output logic [3:0] cause,
    output logic       misaligned
);

    logic mei_q;
    logic msi_q;
    logic mti_q;

    assign mei_q = mie & meie & meip;
    assign msi_q = mie & msie & msip;
    assign mti_q = mie & mtie & mtip;

    // Exceptions are checked before interrupts so a faulting instruction
    // never retires under an interrupt redirect.
    always_comb begin
        take       = 1'b1;
        is_irq     = 1'b0;
        cause      = CAUSE_INSTR_MISALIGN;
        misaligned = 1'b0;
        if (instr_misaligned) begin
            cause      = CAUSE_INSTR_MISALIGN;
            misaligned = 1'b1;
        end else if (illegal_instr) begin
            cause = CAUSE_ILLEGAL;
        end else if (ebreak) begin
            cause = CAUSE_BREAKPOINT;
        end else if (ecall) begin
            cause = CAUSE_ECALL_M;
        end else if (load_misaligned) begin
            cause      = CAUSE_LOAD_MISALIGN;
            misaligned = 1'b1;
        end else if (store_misaligned) begin
            cause      = CAUSE_STORE_MISALIGN;
            misaligned = 1'b1;
        end else if (mei_q) begin
            is_irq = 1'b1;
            cause  = CAUSE_MEI;
        end else if (msi_q) begin
            is_irq = 1'b1;
            cause  = CAUSE_MSI;
        end else if (mti_q) begin
            is_irq = 1'b1;
            cause  = CAUSE_MTI;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/machine_trap_ctrl.sv
// rtl/machine_trap_ctrl.sv - machine-mode trap sequencer for the RV32 core
//
// Purpose: decides when an exception, interrupt or mret redirects the pipeline
//          and drives the trap CSR strobes, PC source select and flush.
// Optional feature: MTRAP_WFI_EN adds wfi_in / stall_out and the WAIT_IRQ state.
// Ports:
//   clk_in, rst_in                 clock, asynchronous active-high reset
//   *_in fault / mret inputs       trap sources from decode and LSU
//   mie_in, m?ie_in, m?ip_in       interrupt enable and pending bits
//   set_cause_out, set_epc_out     mcause/mtval and mepc load strobes
//   misaligned_exception_out       mtval takes the faulting address
//   i_or_e_out, cause_out          mcause[31] and mcause[3:0]
//   mie_clear_out, mie_set_out     mstatus MIE/MPIE update strobes
//   pc_src_out, flush_out          PC mux select and IF/ID kill
module machine_trap_ctrl
    import mtrap_pkg::*;
#(
    parameter logic [1:0] RESET_PC_SRC = 2'b00
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       instr_misaligned_in,
    input  logic       illegal_instr_in,
    input  logic       ebreak_in,
    input  logic       load_misaligned_in,
    input  logic       store_misaligned_in,
    input  logic       ecall_in,
    input  logic       mret_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
`ifdef MTRAP_WFI_EN
    input  logic       wfi_in,
    output logic       stall_out,
`endif
    output logic       set_cause_out,
    output logic       set_epc_out,
    output logic       misaligned_exception_out,
    output logic       i_or_e_out,
    output logic [3:0] cause_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out
);

    mtrap_state_t state;
    mtrap_state_t next_state;

    logic       take;
    logic       is_irq;
    logic [3:0] cause;
    logic       misaligned;
    logic       exc_gate;

    logic       nxt_set_cause;
    logic       nxt_mie_clear;
    logic       nxt_mie_set;
    logic [1:0] nxt_pc_src;
    logic       nxt_flush;

`ifdef MTRAP_WFI_EN
    logic wake;
    logic nxt_stall;

    // WFI wakes on any enabled-and-pending source even with MIE clear.
    assign wake     = (meie_in & meip_in) | (msie_in & msip_in) | (mtie_in & mtip_in);
    // While waiting only interrupts can end the wait, so exceptions are masked
    // from the encoder and the latched cause is always the interrupt's.
    assign exc_gate = (state != WAIT_IRQ);
`else
    assign exc_gate = 1'b1;
`endif

    mtrap_prio_enc u_prio_enc (
        .instr_misaligned (instr_misaligned_in & exc_gate),
        .illegal_instr    (illegal_instr_in    & exc_gate),
        .ebreak           (ebreak_in           & exc_gate),
        .ecall            (ecall_in            & exc_gate),
        .load_misaligned  (load_misaligned_in  & exc_gate),
        .store_misaligned (store_misaligned_in & exc_gate),
        .mie              (mie_in),
        .meie             (meie_in),
        .mtie             (mtie_in),
        .msie             (msie_in),
        .meip             (meip_in),
        .mtip             (mtip_in),
        .msip             (msip_in),
        .take             (take),
        .is_irq           (is_irq),
        .cause            (cause),
        .misaligned       (misaligned)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= OPERATING;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the output values that state will present; registering
    // these keeps every output glitch-free while matching Moore timing.
    always_comb begin
        next_state    = OPERATING;
        nxt_set_cause = 1'b0;
        nxt_mie_clear = 1'b0;
        nxt_mie_set   = 1'b0;
        nxt_pc_src    = PC_SRC_SEQ;
        nxt_flush     = 1'b0;
`ifdef MTRAP_WFI_EN
        nxt_stall     = 1'b0;
`endif
        case (state)
            OPERATING: begin
                if (take) begin
                    next_state = TRAP_TAKEN;
                end else if (mret_in) begin
                    next_state = TRAP_RETURN;
`ifdef MTRAP_WFI_EN
                end else if (wfi_in) begin
                    next_state = WAIT_IRQ;
`endif
                end else begin
                    next_state = OPERATING;
                end
            end
            TRAP_TAKEN:  next_state = OPERATING;
            TRAP_RETURN: next_state = OPERATING;
`ifdef MTRAP_WFI_EN
            WAIT_IRQ: begin
                if (wake) begin
                    next_state = (take && is_irq) ? TRAP_TAKEN : OPERATING;
                end else begin
                    next_state = WAIT_IRQ;
                end
            end
`endif
            default:     next_state = OPERATING;
        endcase

        case (next_state)
            TRAP_TAKEN: begin
                nxt_set_cause = 1'b1;
                nxt_mie_clear = 1'b1;
                nxt_pc_src    = PC_SRC_MTVEC;
                nxt_flush     = 1'b1;
            end
            TRAP_RETURN: begin
                nxt_mie_set = 1'b1;
                nxt_pc_src  = PC_SRC_MEPC;
                nxt_flush   = 1'b1;
            end
`ifdef MTRAP_WFI_EN
            WAIT_IRQ: nxt_stall = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            set_cause_out            <= 1'b0;
            set_epc_out              <= 1'b0;
            mie_clear_out            <= 1'b0;
            mie_set_out              <= 1'b0;
            pc_src_out               <= RESET_PC_SRC;
            flush_out                <= 1'b0;
            cause_out                <= 4'd0;
            i_or_e_out               <= 1'b0;
            misaligned_exception_out <= 1'b0;
`ifdef MTRAP_WFI_EN
            stall_out                <= 1'b0;
`endif
        end else begin
            set_cause_out <= nxt_set_cause;
            set_epc_out   <= nxt_set_cause;
            mie_clear_out <= nxt_mie_clear;
            mie_set_out   <= nxt_mie_set;
            pc_src_out    <= nxt_pc_src;
            flush_out     <= nxt_flush;
`ifdef MTRAP_WFI_EN
            stall_out     <= nxt_stall;
`endif
            // Trap info is captured only on trap entry and held until the next one.
            if (next_state == TRAP_TAKEN) begin
                cause_out                <= cause;
                i_or_e_out               <= is_irq;
                misaligned_exception_out <= misaligned;
            end
        end
    end

endmodule

// File: tb/tb_machine_trap_ctrl.sv
// tb/tb_machine_trap_ctrl.sv - directed self-checking bench for machine_trap_ctrl
module tb_machine_trap_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       instr_misaligned_in = 1'b0;
    logic       illegal_instr_in = 1'b0;
    logic       ebreak_in = 1'b0;
    logic       load_misaligned_in = 1'b0;
    logic       store_misaligned_in = 1'b0;
    logic       ecall_in = 1'b0;
    logic       mret_in = 1'b0;
    logic       mie_in = 1'b0;
    logic       meie_in = 1'b0;
    logic       mtie_in = 1'b0;
    logic       msie_in = 1'b0;
    logic       meip_in = 1'b0;
    logic       mtip_in = 1'b0;
    logic       msip_in = 1'b0;
`ifdef MTRAP_WFI_EN
    logic       wfi_in = 1'b0;
    logic       stall_out;
`endif
    logic       set_cause_out;
    logic       set_epc_out;
    logic       misaligned_exception_out;
    logic       i_or_e_out;
    logic [3:0] cause_out;
    logic       mie_clear_out;
    logic       mie_set_out;
    logic [1:0] pc_src_out;
    logic       flush_out;

    int n_checks = 0;
    int n_fails  = 0;

    machine_trap_ctrl dut (
        .clk_in                   (clk_in),
        .rst_in                   (rst_in),
        .instr_misaligned_in      (instr_misaligned_in),
        .illegal_instr_in         (illegal_instr_in),
        .ebreak_in                (ebreak_in),
        .load_misaligned_in       (load_misaligned_in),
        .store_misaligned_in      (store_misaligned_in),
        .ecall_in                 (ecall_in),
        .mret_in                  (mret_in),
        .mie_in                   (mie_in),
        .meie_in                  (meie_in),
        .mtie_in                  (mtie_in),
        .msie_in                  (msie_in),
        .meip_in                  (meip_in),
        .mtip_in                  (mtip_in),
        .msip_in                  (msip_in),
`ifdef MTRAP_WFI_EN
        .wfi_in                   (wfi_in),
        .stall_out                (stall_out),
`endif
        .set_cause_out            (set_cause_out),
        .set_epc_out              (set_epc_out),
        .misaligned_exception_out (misaligned_exception_out),
        .i_or_e_out               (i_or_e_out),
        .cause_out                (cause_out),
        .mie_clear_out            (mie_clear_out),
        .mie_set_out              (mie_set_out),
        .pc_src_out               (pc_src_out),
        .flush_out                (flush_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_inputs();
        instr_misaligned_in = 1'b0;
        illegal_instr_in    = 1'b0;
        ebreak_in           = 1'b0;
        load_misaligned_in  = 1'b0;
        store_misaligned_in = 1'b0;
        ecall_in            = 1'b0;
        mret_in             = 1'b0;
        mie_in              = 1'b0;
        meie_in             = 1'b0;
        mtie_in             = 1'b0;
        msie_in             = 1'b0;
        meip_in             = 1'b0;
        mtip_in             = 1'b0;
        msip_in             = 1'b0;
    endtask

    // Expect the trap-taken strobe set with the given latched cause info.
    task automatic check_trap(input string tag, input logic [3:0] c, input logic irq, input logic mis);
        check({tag, ".set_cause"}, set_cause_out, 1);
        check({tag, ".set_epc"},   set_epc_out, 1);
        check({tag, ".mie_clear"}, mie_clear_out, 1);
        check({tag, ".flush"},     flush_out, 1);
        check({tag, ".pc_src"},    pc_src_out, 2'b01);
        check({tag, ".mie_set"},   mie_set_out, 0);
        check({tag, ".cause"},     cause_out, c);
        check({tag, ".i_or_e"},    i_or_e_out, irq);
        check({tag, ".misalign"},  misaligned_exception_out, mis);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".set_cause"}, set_cause_out, 0);
        check({tag, ".flush"},     flush_out, 0);
        check({tag, ".pc_src"},    pc_src_out, 2'b00);
        check({tag, ".mie_set"},   mie_set_out, 0);
    endtask

    // Exception priority table: {im, il, eb, ec, lm, sm} -> cause, misaligned
    logic [5:0] prio_vec [4] = '{6'b111111, 6'b011111, 6'b001111, 6'b000011};
    logic [3:0] prio_cau [4] = '{4'd0, 4'd2, 4'd3, 4'd4};
    logic       prio_mis [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset state
        #2;
        check_idle("reset");
        check("reset.cause",  cause_out, 0);
        check("reset.i_or_e", i_or_e_out, 0);
        check("reset.epc",    set_epc_out, 0);
        #10 rst_in = 1'b0;
        tick();
        check_idle("post_reset");

        // Load misaligned
        load_misaligned_in = 1'b1;
        tick();
        load_misaligned_in = 1'b0;
        check_trap("load_mis", 4'd4, 1'b0, 1'b1);
        tick();
        check_idle("load_mis_after");
        check("load_mis_hold.cause", cause_out, 4);

        // Exception beats interrupt
        illegal_instr_in = 1'b1;
        ecall_in         = 1'b1;
        mie_in = 1'b1; meie_in = 1'b1; meip_in = 1'b1;
        tick();
        check_trap("exc_vs_irq", 4'd2, 1'b0, 1'b0);
        illegal_instr_in = 1'b0;
        ecall_in         = 1'b0;
        tick();
        check_idle("exc_vs_irq_gap");
        tick();
        check_trap("mei", 4'd11, 1'b1, 1'b0);
        meip_in = 1'b0;
        tick();
        check_idle("mei_after");

        // Interrupt masking
        clear_inputs();
        mtie_in = 1'b1; mtip_in = 1'b1;
        tick();
        check_idle("mti_masked0");
        tick();
        check_idle("mti_masked1");
        mie_in = 1'b1;
        tick();
        check_trap("mti", 4'd7, 1'b1, 1'b0);
        msie_in = 1'b1; msip_in = 1'b1;
        tick();
        tick();
        check_trap("msi_over_mti", 4'd3, 1'b1, 1'b0);
        clear_inputs();
        tick();

        // MRET
        mret_in = 1'b1;
        tick();
        mret_in = 1'b0;
        check("mret.mie_set",   mie_set_out, 1);
        check("mret.pc_src",    pc_src_out, 2'b10);
        check("mret.flush",     flush_out, 1);
        check("mret.set_cause", set_cause_out, 0);
        check("mret.mie_clear", mie_clear_out, 0);
        tick();
        check_idle("mret_after");
        mret_in = 1'b1;
        store_misaligned_in = 1'b1;
        tick();
        clear_inputs();
        check_trap("mret_vs_store", 4'd6, 1'b0, 1'b1);
        tick();

        // Exception priority table
        for (int i = 0; i < 4; i++) begin
            {instr_misaligned_in, illegal_instr_in, ebreak_in,
             ecall_in, load_misaligned_in, store_misaligned_in} = prio_vec[i];
            tick();
            clear_inputs();
            check_trap($sformatf("prio%0d", i), prio_cau[i], 1'b0, prio_mis[i]);
            tick();
        end
        ecall_in = 1'b1;
        load_misaligned_in = 1'b1;
        tick();
        clear_inputs();
        check_trap("ecall_over_load", 4'd11, 1'b0, 1'b0);
        tick();

        // Reset in the middle of TRAP_TAKEN
        ebreak_in = 1'b1;
        tick();
        ebreak_in = 1'b0;
        check_trap("pre_rst", 4'd3, 1'b0, 1'b0);
        #2 rst_in = 1'b1;
        #1;
        check("rst_mid.set_cause", set_cause_out, 0);
        check("rst_mid.set_epc",   set_epc_out, 0);
        check("rst_mid.flush",     flush_out, 0);
        check("rst_mid.pc_src",    pc_src_out, 0);
        check("rst_mid.cause",     cause_out, 0);
        #8 rst_in = 1'b0;
        tick();
        check_idle("rst_release");
        check("rst_release.cause", cause_out, 0);
        check("rst_release.mie_clear", mie_clear_out, 0);

`ifdef MTRAP_WFI_EN
        // WFI: stall until a wake source, resume without trap when MIE is clear
        wfi_in = 1'b1;
        tick();
        wfi_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wfi_stall%0d", i), stall_out, 1);
            check($sformatf("wfi_pc%0d", i), pc_src_out, 0);
            tick();
        end
        mtie_in = 1'b1; mtip_in = 1'b1;
        tick();
        check("wfi_resume.stall", stall_out, 0);
        check_idle("wfi_resume");
        tick();
        check_idle("wfi_resume2");
        clear_inputs();
        wfi_in = 1'b1;
        tick();
        wfi_in = 1'b0;
        check("wfi2.stall", stall_out, 1);
        mie_in = 1'b1; mtie_in = 1'b1; mtip_in = 1'b1;
        tick();
        check("wfi2_trap.stall", stall_out, 0);
        check_trap("wfi2_trap", 4'd7, 1'b1, 1'b0);
        clear_inputs();
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
